// File: rtl/ippcrc_crc12_sched.sv
// Round-robin scheduler sharing one 80-bit/cycle CRC-12 core across NCH frame streams.
// Per-channel running CRC state, one registered result slot, one-cycle protocol error pulses.

// Combinational CRC-12 (x^12+x^11+x^3+x^2+x+1) over 80 bits, di[79] shifted in first.
module ippcrc_crc12_80b (
  input  logic [11:0] ci,
  input  logic [79:0] di,
  output logic [11:0] co
);
  localparam logic [11:0] POLY = 12'h80F;

  logic [11:0] c;
  logic        fb;

  always_comb begin
    c  = ci;
    fb = 1'b0;
    for (int i = 79; i >= 0; i--) begin
      fb = c[11] ^ di[i];
      c  = {c[10:0], 1'b0} ^ (fb ? POLY : 12'h000);
    end
    co = c;
  end
endmodule

// Per-channel frame state: running CRC and in-frame flag.
module ippcrc_crc12_chst #(
  parameter logic [11:0] SEED = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        upd,
  input  logic        eop,
  input  logic [11:0] co,
  output logic [11:0] st,
  output logic        infrm
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= SEED;
      infrm <= 1'b0;
    end else if (upd) begin
      infrm <= ~eop;
      st    <= eop ? SEED : co;
    end
  end
endmodule

module ippcrc_crc12_sched #(
  parameter int          NCH    = 2,
  parameter int          CHW    = 1,
  parameter logic [11:0] SEED   = 12'hFFF,
  parameter logic [11:0] XOROUT = 12'h000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH-1:0]        ch_vld,
  input  logic [NCH-1:0]        ch_sop,
  input  logic [NCH-1:0]        ch_eop,
  input  logic [NCH-1:0][79:0]  ch_dat,
  output logic [NCH-1:0]        ch_rdy,
  output logic                  res_vld,
  input  logic                  res_rdy,
  output logic [CHW-1:0]        res_ch,
  output logic [11:0]           res_crc,
  output logic                  err_sop,
  output logic                  err_nosop,
  output logic [CHW-1:0]        err_ch
);
  logic [NCH-1:0][11:0] st;
  logic [NCH-1:0]       infrm;
  logic [NCH-1:0]       elig;
  logic [NCH-1:0]       gnt;
  logic [CHW-1:0]       ptr;
  logic [CHW-1:0]       g;
  logic                 xfer;
  int                   idx;

  logic                 sop_g, eop_g, infrm_g, frm_ok, load;
  logic [11:0]          ci, co;
  logic [79:0]          dat_g;

  // An eop word needs the result slot free (or draining this cycle).
  assign elig = ch_vld & ~(ch_eop & {NCH{res_vld & ~res_rdy}});

  always_comb begin
    gnt  = '0;
    g    = '0;
    xfer = 1'b0;
    idx  = 0;
    for (int k = 1; k <= NCH; k++) begin
      idx = (int'(ptr) + k) % NCH;
      if (!xfer && elig[idx]) begin
        xfer = 1'b1;
        g    = CHW'(idx);
      end
    end
    if (xfer) gnt[g] = 1'b1;
  end

  assign ch_rdy  = gnt;
  assign sop_g   = ch_sop[g];
  assign eop_g   = ch_eop[g];
  assign infrm_g = infrm[g];
  assign dat_g   = ch_dat[g];
  assign ci      = sop_g ? SEED : st[g];
  assign frm_ok  = sop_g | infrm_g;
  assign load    = xfer & eop_g & frm_ok;

  ippcrc_crc12_80b u_core (.ci(ci), .di(dat_g), .co(co));

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    ippcrc_crc12_chst #(.SEED(SEED)) u_chst (
      .clk   (clk),
      .rst_n (rst_n),
      .upd   (gnt[i] & (ch_sop[i] | infrm[i])),
      .eop   (ch_eop[i]),
      .co    (co),
      .st    (st[i]),
      .infrm (infrm[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= CHW'(NCH - 1);
    else if (xfer) ptr <= g;
  end

  // A load in the same cycle as a drain wins, so the new result is presented next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_vld <= 1'b0;
      res_ch  <= '0;
      res_crc <= '0;
    end else if (load) begin
      res_vld <= 1'b1;
      res_ch  <= g;
      res_crc <= co ^ XOROUT;
    end else if (res_rdy) begin
      res_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sop   <= 1'b0;
      err_nosop <= 1'b0;
      err_ch    <= '0;
    end else begin
      err_sop   <= xfer & sop_g & infrm_g;
      err_nosop <= xfer & ~frm_ok;
      if (xfer & ((sop_g & infrm_g) | ~frm_ok)) err_ch <= g;
    end
  end
endmodule

// File: tb/tb_ippcrc_crc12_sched.sv
// Self-checking bench: frame-level reference model (CRC by polynomial long division),
// one-word frame table, randomized round-robin traffic and directed corner sequences.
module tb_ippcrc_crc12_sched;
  localparam int          NCH    = 2;
  localparam int          CHW    = 1;
  localparam logic [11:0] SEED_A = 12'hFFF;
  localparam logic [11:0] XOR_A  = 12'h000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NCH-1:0]       ch_vld, ch_sop, ch_eop;
  logic [NCH-1:0][79:0] ch_dat;
  logic                 res_rdy;

  logic [NCH-1:0] a_rdy, b_rdy, c_rdy;
  logic           a_rv, b_rv, c_rv, a_es, b_es, c_es, a_en, b_en, c_en;
  logic [CHW-1:0] a_rch, b_rch, c_rch, a_ech, b_ech, c_ech;
  logic [11:0]    a_crc, b_crc, c_crc;

  ippcrc_crc12_sched #(.NCH(NCH), .CHW(CHW), .SEED(SEED_A), .XOROUT(XOR_A)) u_a (
    .clk(clk), .rst_n(rst_n), .ch_vld(ch_vld), .ch_sop(ch_sop), .ch_eop(ch_eop),
    .ch_dat(ch_dat), .ch_rdy(a_rdy), .res_vld(a_rv), .res_rdy(res_rdy), .res_ch(a_rch),
    .res_crc(a_crc), .err_sop(a_es), .err_nosop(a_en), .err_ch(a_ech));
  ippcrc_crc12_sched #(.NCH(NCH), .CHW(CHW), .SEED(12'h000), .XOROUT(12'hABC)) u_b (
    .clk(clk), .rst_n(rst_n), .ch_vld(ch_vld), .ch_sop(ch_sop), .ch_eop(ch_eop),
    .ch_dat(ch_dat), .ch_rdy(b_rdy), .res_vld(b_rv), .res_rdy(res_rdy), .res_ch(b_rch),
    .res_crc(b_crc), .err_sop(b_es), .err_nosop(b_en), .err_ch(b_ech));
  ippcrc_crc12_sched #(.NCH(NCH), .CHW(CHW), .SEED(12'h000), .XOROUT(12'h000)) u_c (
    .clk(clk), .rst_n(rst_n), .ch_vld(ch_vld), .ch_sop(ch_sop), .ch_eop(ch_eop),
    .ch_dat(ch_dat), .ch_rdy(c_rdy), .res_vld(c_rv), .res_rdy(res_rdy), .res_ch(c_rch),
    .res_crc(c_crc), .err_sop(c_es), .err_nosop(c_en), .err_ch(c_ech));

  int n_chk = 0;
  int n_pass = 0;

  // Reference state, kept at frame level.
  int                 m_last;
  bit                 m_inf [NCH];
  logic [16*80-1:0]   m_msg [NCH];
  int                 m_n   [NCH];
  bit                 m_rv, m_es, m_en;
  int                 m_rch, m_ech;
  logic [11:0]        m_rcrc;

  typedef struct {
    int          ch;
    logic [79:0] dat;
    logic [11:0] exp_b;
    logic [11:0] exp_c;
  } vec_t;
  vec_t tv [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Seed folded into the first 12 message bits, 12 zero bits appended, remainder mod G.
  function automatic logic [11:0] crc_ref(input logic [11:0] seed, input logic [16*80-1:0] msg,
                                          input int nw);
    bit          b[$];
    logic [12:0] gp = 13'h180F;
    logic [11:0] r  = '0;
    for (int k = 0; k < nw; k++)
      for (int i = 79; i >= 0; i--) b.push_back(msg[80*k + i]);
    for (int i = 0; i < 12; i++) b[i] = b[i] ^ seed[11-i];
    repeat (12) b.push_back(1'b0);
    for (int i = 0; i <= b.size() - 13; i++)
      if (b[i])
        for (int j = 0; j <= 12; j++) b[i+j] = b[i+j] ^ gp[12-j];
    for (int j = 0; j < 12; j++) r[11-j] = b[b.size() - 12 + j];
    return r;
  endfunction

  function automatic logic [16*80-1:0] frm(input logic [79:0] w0, input logic [79:0] w1);
    logic [16*80-1:0] m = '0;
    m[79:0]    = w0;
    m[159:80]  = w1;
    return m;
  endfunction

  function automatic logic [79:0] rnd80();
    logic [95:0] t = {$urandom, $urandom, $urandom};
    return t[79:0];
  endfunction

  task automatic model_reset();
    m_last = NCH - 1;
    m_rv = 0; m_es = 0; m_en = 0;
    for (int i = 0; i < NCH; i++) begin m_inf[i] = 0; m_n[i] = 0; m_msg[i] = '0; end
  endtask

  // One clock: check grant before the edge, advance the model at the edge, check regs after.
  task automatic tick(output logic [NCH-1:0] gv);
    int w = -1;
    bit blk;
    #1;
    gv  = '0;
    blk = m_rv && !res_rdy;
    for (int k = 1; k <= NCH; k++) begin
      int cc = (m_last + k) % NCH;
      if (w < 0 && ch_vld[cc] && !(ch_eop[cc] && blk)) w = cc;
    end
    if (w >= 0) gv[w] = 1'b1;
    chk("ch_rdy", 32'(a_rdy), 32'(gv));
    @(posedge clk);
    m_es = 0; m_en = 0;
    if (m_rv && res_rdy) m_rv = 0;
    if (w >= 0) begin
      m_last = w;
      if (ch_sop[w]) begin
        if (m_inf[w]) begin m_es = 1; m_ech = w; end
        m_n[w] = 0;
      end
      if (ch_sop[w] || m_inf[w]) begin
        if (m_n[w] < 16) begin
          m_msg[w][80*m_n[w] +: 80] = ch_dat[w];
          m_n[w]++;
        end
        m_inf[w] = !ch_eop[w];
        if (ch_eop[w]) begin
          m_rv = 1; m_rch = w;
          m_rcrc = crc_ref(SEED_A, m_msg[w], m_n[w]) ^ XOR_A;
        end
      end else begin
        m_en = 1; m_ech = w;
      end
    end
    @(negedge clk);
    chk("res_vld", 32'(a_rv), 32'(m_rv));
    if (m_rv) begin
      chk("res_ch", 32'(a_rch), 32'(m_rch));
      chk("res_crc", 32'(a_crc), 32'(m_rcrc));
    end
    chk("err_sop", 32'(a_es), 32'(m_es));
    chk("err_nosop", 32'(a_en), 32'(m_en));
    if (m_es || m_en) chk("err_ch", 32'(a_ech), 32'(m_ech));
  endtask

  task automatic send(input int ch, input bit s, input bit e, input logic [79:0] d);
    logic [NCH-1:0] gv;
    bit ok = 0;
    ch_vld = '0; ch_sop = '0; ch_eop = '0;
    ch_vld[ch] = 1'b1; ch_sop[ch] = s; ch_eop[ch] = e; ch_dat[ch] = d;
    for (int t = 0; t < 16 && !ok; t++) begin
      tick(gv);
      ok = gv[ch];
    end
    ch_vld = '0; ch_sop = '0; ch_eop = '0;
    chk("send_accepted", 32'(ok), 32'd1);
  endtask

  task automatic idle(input int n);
    logic [NCH-1:0] gv;
    ch_vld = '0;
    repeat (n) tick(gv);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NCH-1:0] gv;
    logic [79:0]    w0, w1, w2, w3;
    int idx [NCH], len [NCH], left [NCH];
    logic [79:0] d [NCH];
    bit busy;

    ch_vld = '0; ch_sop = '0; ch_eop = '0; ch_dat = '0; res_rdy = 1'b1;
    rst_n = 1'b0;
    model_reset();

    tv[0] = '{0, 80'h0, 12'hABC, 12'h000};
    tv[1] = '{1, 80'h0, 12'hABC, 12'h000};
    tv[2].ch = 0; tv[2].dat = rnd80();
    tv[3].ch = 1; tv[3].dat = '1;
    for (int i = 2; i < 4; i++) begin
      tv[i].exp_c = crc_ref(12'h000, frm(tv[i].dat, 80'h0), 1);
      tv[i].exp_b = tv[i].exp_c ^ 12'hABC;
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_res_vld", 32'(a_rv), 0);
    chk("rst_res_ch", 32'(a_rch), 0);
    chk("rst_res_crc", 32'(a_crc), 0);
    chk("rst_err_sop", 32'(a_es), 0);
    chk("rst_err_nosop", 32'(a_en), 0);
    chk("rst_err_ch", 32'(a_ech), 0);
    chk("rst_ch_rdy", 32'(a_rdy), 0);
    rst_n = 1'b1;

    // One-word frames across seed/xorout variants
    for (int i = 0; i < 4; i++) begin
      send(tv[i].ch, 1, 1, tv[i].dat);
      chk("tv_b_vld", 32'(b_rv), 1);
      chk("tv_b_crc", 32'(b_crc), 32'(tv[i].exp_b));
      chk("tv_c_crc", 32'(c_crc), 32'(tv[i].exp_c));
      chk("tv_c_ch", 32'(c_rch), 32'(tv[i].ch));
      idle(1);
    end

    // Randomized traffic: phase 0 fixed 3-word frames, phase 1 random lengths and backpressure
    for (int p = 0; p < 2; p++) begin
      do_reset();
      res_rdy = 1'b1;
      for (int c = 0; c < NCH; c++) begin
        idx[c] = 0; left[c] = 6; d[c] = rnd80();
        len[c] = (p == 0) ? 3 : int'($urandom_range(1, 4));
      end
      busy = 1;
      for (int cyc = 0; cyc < 400 && busy; cyc++) begin
        for (int c = 0; c < NCH; c++) begin
          ch_vld[c] = left[c] > 0;
          ch_sop[c] = idx[c] == 0;
          ch_eop[c] = idx[c] == len[c] - 1;
          ch_dat[c] = d[c];
        end
        if (p == 1) res_rdy = 1'($urandom_range(0, 1));
        tick(gv);
        busy = 0;
        for (int c = 0; c < NCH; c++) begin
          if (gv[c]) begin
            idx[c]++;
            d[c] = rnd80();
            if (idx[c] == len[c]) begin
              idx[c] = 0; left[c]--;
              len[c] = (p == 0) ? 3 : int'($urandom_range(1, 4));
            end
          end
          if (left[c] > 0) busy = 1;
        end
      end
      chk("rr_all_frames_done", 32'(busy), 0);
      ch_vld = '0; ch_sop = '0; ch_eop = '0; res_rdy = 1'b1;
      idle(2);
    end

    // Result slot full: ch1 eop blocked, non-eop words still accepted, single-cycle drain admits it
    res_rdy = 1'b0;
    send(0, 1, 1, rnd80());
    chk("bp_pending", 32'(a_rv), 1);
    send(1, 1, 0, rnd80());
    ch_vld[1] = 1'b1; ch_sop[1] = 1'b0; ch_eop[1] = 1'b1; ch_dat[1] = rnd80();
    tick(gv);
    tick(gv);
    chk("bp_eop_blocked", 32'(a_rdy), 0);
    res_rdy = 1'b1;
    tick(gv);
    chk("bp_eop_granted", 32'(gv), 32'b10);
    ch_vld = '0; ch_eop = '0; res_rdy = 1'b0;
    chk("bp_new_result_ch", 32'(a_rch), 1);
    tick(gv);
    res_rdy = 1'b1;
    idle(2);

    // Restart without eop: second frame only
    w0 = rnd80(); w1 = rnd80(); w2 = rnd80(); w3 = rnd80();
    send(0, 1, 0, w0);
    send(0, 0, 0, w1);
    send(0, 1, 0, w2);
    chk("dup_sop_pulse", 32'(a_es), 1);
    chk("dup_sop_ch", 32'(a_ech), 0);
    send(0, 0, 1, w3);
    chk("dup_sop_crc", 32'(a_crc), 32'(crc_ref(SEED_A, frm(w2, w3), 2) ^ XOR_A));
    idle(1);
    chk("dup_sop_pulse_gone", 32'(a_es), 0);

    // Orphan eop on an idle channel
    send(1, 0, 1, rnd80());
    chk("nosop_pulse", 32'(a_en), 1);
    chk("nosop_ch", 32'(a_ech), 1);
    chk("nosop_no_result", 32'(a_rv), 0);
    idle(1);

    // Asynchronous reset mid-frame with a pending result
    res_rdy = 1'b0;
    send(1, 1, 1, rnd80());
    send(0, 1, 0, w1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_res_vld", 32'(a_rv), 0);
    chk("async_rst_res_crc", 32'(a_crc), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    res_rdy = 1'b1;
    send(0, 1, 0, w1);
    send(0, 0, 1, w2);
    chk("post_rst_crc", 32'(a_crc), 32'(crc_ref(SEED_A, frm(w1, w2), 2) ^ XOR_A));
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ippcrc_crc12_sched.md
Name: ippcrc_crc12_sched

Overview:
- Shares one combinational 80-bit-per-cycle CRC-12 core (ippcrc_crc12_80b, instantiated inside this block) between NCH independent frame streams.
- Round-robin arbitration accepts at most one 80-bit word per cycle.
- Keeps a CRC-12 running state per channel and returns one registered result per frame.
- Sits between packet framers (requesters) and the ECC/OAM logic that consumes frame CRCs.

Parameters:
NCH, 2, number of requester channels (2..8)
CHW, 1, channel-id width, ceil(log2(NCH)), minimum 1
SEED, 12'hFFF, CRC state loaded at start of frame
XOROUT, 12'h000, value XORed onto final CRC at result output

Ports:
clk  in  1  clock; all flops rising-edge
rst_n  in  1  asynchronous active-low reset
ch_vld  in  NCH  word valid per channel
ch_sop  in  NCH  word is first of frame
ch_eop  in  NCH  word is last of frame (sop&eop = one-word frame)
ch_dat  in  NCH*80  data; channel i at [80*i+79:80*i], di[79:0] core convention
ch_rdy  out  NCH  grant/accept; one-hot or zero
res_vld  out  1  result valid, held until res_rdy
res_rdy  in  1  result consumer ready
res_ch  out  CHW  channel id of result
res_crc  out  12  final CRC (co ^ XOROUT)
err_sop  out  1  1-cycle pulse: sop accepted on channel already in frame
err_nosop  out  1  1-cycle pulse: non-sop word accepted on idle channel (word discarded)
err_ch  out  CHW  channel of the error pulse

Behaviour:
- Reset: res_vld=0, res_ch=0, res_crc=0, err_sop=0, err_nosop=0, err_ch=0. All crc_st[i]=SEED, all infrm[i]=0. RR pointer=NCH-1, so ch0 has first priority.
- Transfer on channel i = ch_vld[i] & ch_rdy[i]. ch_rdy is combinational from ch_vld/ch_eop/res state. Requesters hold vld/sop/eop/dat stable until accepted.
- Eligibility: elig[i] = ch_vld[i] & ~(ch_eop[i] & res_vld & ~res_rdy). An eop word is blocked only while the result slot stays full. A slot drained in the same cycle (res_vld&res_rdy) admits the eop.
- Arbitration: round-robin among elig. Search starts at ptr+1 modulo NCH. ch_rdy = one-hot of the winner. On any transfer, ptr <= winner. With no transfer, ptr holds.
- Core inputs for granted channel g: ci = ch_sop[g] ? SEED : crc_st[g]; di = ch_dat[g].
- On transfer, with co = core output:
  - sop: infrm[g] <= ~eop; crc_st[g] <= eop ? SEED : co.
  - If infrm[g] was already 1: err_sop pulse, err_ch=g. The old frame is abandoned with no result, and the new frame starts.
  - non-sop, infrm[g]=1: crc_st[g] <= eop ? SEED : co; infrm[g] <= ~eop.
  - non-sop, infrm[g]=0: word dropped; err_nosop pulse, err_ch=g. State unchanged; no result even if eop.
  - eop with a valid frame: res_vld <= 1, res_ch <= g, res_crc <= co ^ XOROUT. Latency: result visible the cycle after the eop is accepted.
- Result slot: res_vld clears on res_vld&res_rdy unless a new eop loads it in the same cycle. A simultaneous drain and load presents the new result next cycle.
- Error pulses last exactly one cycle. err_sop and err_nosop are mutually exclusive because there is one transfer per cycle.
- Other channels' crc_st/infrm are never touched by a transfer on g. Frames on different channels interleave word-by-word.
- Throughput: 1 word/cycle aggregate. Worst-case wait for an eligible channel is NCH-1 cycles.
- rst_n assertion mid-frame: all frames abandoned, pending result lost, outputs return to reset values immediately (asynchronous).

Test Plan:
- SEED=0, XOROUT=0: ch0 one-word frame (sop=eop=1), dat=80'h0 -> next cycle res_vld=1, res_ch=0, res_crc=12'h000. XOROUT=12'hABC -> res_crc=12'hABC.
- NCH=2, both channels vld continuously with 3-word frames (random data) -> ch_rdy alternates 01,10,01,... starting ch0. res_crc per channel matches a bit-serial CRC-12 reference model seeded with SEED, x^12+x^11+x^3+x^2+x+1, 240 bits.
- res_rdy=0 holding ch0 result; ch1 presents eop -> ch1 rdy stays 0, ch1 non-eop words still accepted. Raise res_rdy for 1 cycle -> ch1 eop accepted that same cycle, ch1 result on res_crc next cycle.
- ch0 sop, word, then sop again (no eop) -> err_sop=1 for 1 cycle, err_ch=0. Final CRC equals that of the second frame only.
- ch1 non-sop word with eop while idle -> err_nosop=1, err_ch=1, no res_vld.
- Assert rst_n=0 mid-frame on ch0 with res_vld=1 pending -> res_vld=0 immediately. After release, a new ch0 frame gives the same CRC as from reset.
